card_shoe: RTL and testbench

Upstream card source for the blackjack game FSM. Replaces the free-running counters as the source of card values. Models a shoe of `DECKS` standard decks, tracking how many cards of each rank remain. On a one-cycle draw request it returns a random card that is still in the shoe, using a 16-bit LFSR with rejection sampling. The game FSM adds the returned `card_value` to the player or dealer hand.

---
 rtl/bj_pkg.sv | 45 ++++
 rtl/lfsr16.sv | 28 ++
 rtl/card_shoe.sv | 106 ++++++++++
 tb/tb_card_shoe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared blackjack definitions: rank encoding, rank-to-value mapping, shoe FSM states.
package bj_pkg;

  localparam int unsigned RANK_W    = 4;
  localparam int unsigned VALUE_W   = 5;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned LEFT_W    = 8;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned NUM_RANKS = 13;
  localparam int unsigned HAND_MAX  = 21;

  localparam logic [RANK_W-1:0] RANK_ACE   = 4'd0;
  localparam logic [RANK_W-1:0] RANK_TWO   = 4'd1;
  localparam logic [RANK_W-1:0] RANK_THREE = 4'd2;
  localparam logic [RANK_W-1:0] RANK_FOUR  = 4'd3;
  localparam logic [RANK_W-1:0] RANK_FIVE  = 4'd4;
  localparam logic [RANK_W-1:0] RANK_SIX   = 4'd5;
  localparam logic [RANK_W-1:0] RANK_SEVEN = 4'd6;
  localparam logic [RANK_W-1:0] RANK_EIGHT = 4'd7;
  localparam logic [RANK_W-1:0] RANK_NINE  = 4'd8;
  localparam logic [RANK_W-1:0] RANK_TEN   = 4'd9;
  localparam logic [RANK_W-1:0] RANK_JACK  = 4'd10;
  localparam logic [RANK_W-1:0] RANK_QUEEN = 4'd11;
  localparam logic [RANK_W-1:0] RANK_KING  = 4'd12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // Hard value of a rank; aces count as 1, the consumer decides on 11.
  function automatic logic [VALUE_W-1:0] rank_to_value(input logic [RANK_W-1:0] rank);
    logic [VALUE_W-1:0] value;
    if (rank == RANK_ACE) begin
      value = VALUE_W'(1);
    end else if (rank <= RANK_TEN) begin
      value = VALUE_W'(rank) + VALUE_W'(1);
    end else begin
      value = VALUE_W'(10);
    end
    return value;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
module lfsr16
  import bj_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              Clock,
  input  logic              reset_n,
  output logic [LFSR_W-1:0] q
);

  logic fb_c;

  // Feedback from taps 16, 14, 13, 11 (bit 16 is the MSB).
  always_comb begin
    fb_c = q[15] ^ q[13] ^ q[12] ^ q[10];
  end

  // Shift toward the MSB every cycle, feedback enters at the LSB.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else begin
      q <= {q[LFSR_W-2:0], fb_c};
    end
  end

endmodule

// File: rtl/card_shoe.sv
// Card shoe: per-rank counts of a DECKS-deck shoe, random draw by LFSR rejection sampling.
module card_shoe
  import bj_pkg::*;
#(
  parameter int unsigned       DECKS     = 1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic               Clock,
  input  logic               reset_n,
  input  logic               draw_req,
  input  logic               shuffle,
  output logic               card_valid,
  output logic [VALUE_W-1:0] card_value,
  output logic [RANK_W-1:0]  card_rank,
  output logic               card_is_ace,
  output logic               empty_err,
  output logic               busy,
  output logic [LEFT_W-1:0]  cards_left
);

  localparam logic [CNT_W-1:0]  RANK_FULL = CNT_W'(4 * DECKS);
  localparam logic [LEFT_W-1:0] SHOE_FULL = LEFT_W'(52 * DECKS);

  state_t                           state;
  logic [NUM_RANKS-1:0][CNT_W-1:0]  rank_cnt;
  logic [LFSR_W-1:0]                lfsr_q;
  logic [RANK_W-1:0]                cand;
  logic                             hit_c;
  logic                             unused_lfsr_bits;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clock   (Clock),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  assign cand             = lfsr_q[RANK_W-1:0];
  assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:RANK_W];

  // Candidate is accepted when it names a real rank that still has cards.
  always_comb begin
    hit_c = 1'b0;
    if (cand <= RANK_KING) begin
      hit_c = (rank_cnt[cand] != '0);
    end
  end

  // Draw FSM, rank store and registered outputs; shuffle overrides every state.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rank_cnt    <= {NUM_RANKS{RANK_FULL}};
      cards_left  <= SHOE_FULL;
      card_valid  <= 1'b0;
      empty_err   <= 1'b0;
      busy        <= 1'b0;
      card_value  <= '0;
      card_rank   <= '0;
      card_is_ace <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      if (shuffle) begin
        rank_cnt   <= {NUM_RANKS{RANK_FULL}};
        cards_left <= SHOE_FULL;
        state      <= IDLE;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (draw_req) begin
              if (cards_left == '0) begin
                empty_err <= 1'b1;
              end else begin
                state <= SEARCH;
                busy  <= 1'b1;
              end
            end
          end
          SEARCH: begin
            if (hit_c) begin
              rank_cnt[cand] <= rank_cnt[cand] - CNT_W'(1);
              cards_left     <= cards_left - LEFT_W'(1);
              card_rank      <= cand;
              card_value     <= rank_to_value(cand);
              card_is_ace    <= (cand == RANK_ACE);
              card_valid     <= 1'b1;
              state          <= DELIVER;
            end
          end
          DELIVER: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: LFSR-based prediction, scoreboard of expected deliveries.
module tb_card_shoe;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       rst_n;
  logic       draw_req;
  logic       shuffle;
  logic       card_valid;
  logic [4:0] card_value;
  logic [3:0] card_rank;
  logic       card_is_ace;
  logic       empty_err;
  logic       busy;
  logic [7:0] cards_left;

  card_shoe #(
    .DECKS     (1),
    .LFSR_SEED (SEED)
  ) dut (
    .Clock       (clk),
    .reset_n     (rst_n),
    .draw_req    (draw_req),
    .shuffle     (shuffle),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .card_rank   (card_rank),
    .card_is_ace (card_is_ace),
    .empty_err   (empty_err),
    .busy        (busy),
    .cards_left  (cards_left)
  );

  typedef struct {
    bit is_empty;
    int rank;
    int value;
    int ace;
    int left;
    int due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          m_cnt[13];
  int          m_left;
  int          seen[13];
  logic [15:0] m_lfsr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int exp_value(input int r);
    if (r == 0) return 1;
    if (r >= 10) return 10;
    return r + 1;
  endfunction

  // Reference LFSR running alongside the DUT's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic refill_model();
    for (int i = 0; i < 13; i++) m_cnt[i] = 4;
    m_left = 52;
  endtask

  // Called in the cycle draw_req is driven; predicts the outcome and its arrival cycle.
  task automatic predict_draw(output int k);
    exp_t        e;
    logic [15:0] c;
    int          r;
    k = 0;
    if (m_left == 0) begin
      e.is_empty = 1'b1;
      e.rank = 0; e.value = 0; e.ace = 0; e.left = 0;
      e.due = cyc + 1;
    end else begin
      c = lfsr_next(m_lfsr);
      k = 1;
      while (!(c[3:0] <= 4'd12 && m_cnt[c[3:0]] > 0) && k < 3000) begin
        c = lfsr_next(c);
        k++;
      end
      r = int'(c[3:0]);
      if (r > 12) r = 0;
      m_cnt[r]--;
      m_left--;
      e.is_empty = 1'b0;
      e.rank  = r;
      e.value = exp_value(r);
      e.ace   = (r == 0) ? 1 : 0;
      e.left  = m_left;
      e.due   = cyc + 1 + k;
    end
    sb.push_back(e);
  endtask

  task automatic draw(output int k);
    draw_req = 1'b1;
    predict_draw(k);
    @(negedge clk);
    draw_req = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every delivery or empty pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (card_valid && card_rank < 4'd13) seen[card_rank] = seen[card_rank] + 1;
      if (card_valid || empty_err) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {30'd0, card_valid, empty_err}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_empty) begin
            check("empty_err", 32'(empty_err), 32'd1);
            check("empty_no_valid", 32'(card_valid), 32'd0);
            check("empty_time", 32'(cyc), 32'(mon_e.due));
          end else begin
            check("card_valid", 32'(card_valid), 32'd1);
            check("card_rank", 32'(card_rank), 32'(mon_e.rank));
            check("card_value", 32'(card_value), 32'(mon_e.value));
            check("card_is_ace", 32'(card_is_ace), 32'(mon_e.ace));
            check("cards_left", 32'(cards_left), 32'(mon_e.left));
            check("card_time", 32'(cyc), 32'(mon_e.due));
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check("missing_output", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int k;
    rst_n    = 1'b1;
    draw_req = 1'b0;
    shuffle  = 1'b0;
    for (int i = 0; i < 13; i++) seen[i] = 0;
    refill_model();

    #2 rst_n = 1'b0;
    #1;
    check("rst_card_valid", 32'(card_valid), 32'd0);
    check("rst_empty_err", 32'(empty_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_card_value", 32'(card_value), 32'd0);
    check("rst_card_rank", 32'(card_rank), 32'd0);
    check("rst_card_is_ace", 32'(card_is_ace), 32'd0);
    check("rst_cards_left", 32'(cards_left), 32'd52);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First draw, then drain the whole shoe.
    draw(k);
    check("busy_in_search", 32'(busy), 32'd1);
    wait_idle();
    check("left_after_first", 32'(cards_left), 32'd51);
    repeat (51) begin
      draw(k);
      wait_idle();
    end
    check("left_after_52", 32'(cards_left), 32'd0);
    for (int i = 0; i < 13; i++) check($sformatf("rank_count_%0d", i), 32'(seen[i]), 32'd4);

    // Request on an empty shoe.
    draw(k);
    wait_idle();
    check("left_still_0", 32'(cards_left), 32'd0);
    check("busy_after_empty", 32'(busy), 32'd0);

    // Shuffle refill, ten draws, shuffle again, one draw.
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    refill_model();
    check("left_after_shuffle", 32'(cards_left), 32'd52);
    repeat (10) begin
      draw(k);
      wait_idle();
    end
    check("left_after_10", 32'(cards_left), 32'd42);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    refill_model();
    check("left_after_reshuffle", 32'(cards_left), 32'd52);
    draw(k);
    wait_idle();
    check("left_after_redraw", 32'(cards_left), 32'd51);

    // Shuffle while searching aborts the draw.
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check("search_before_abort", 32'(busy), 32'd1);
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    refill_model();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_left", 32'(cards_left), 32'd52);
    check("abort_no_valid", 32'(card_valid), 32'd0);
    repeat (30) @(negedge clk);

    // Draw and shuffle in the same cycle: draw dropped.
    draw_req = 1'b1;
    shuffle  = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    shuffle  = 1'b0;
    refill_model();
    check("same_cycle_busy", 32'(busy), 32'd0);
    check("same_cycle_left", 32'(cards_left), 32'd52);
    repeat (30) @(negedge clk);

    // Request held through SEARCH and DELIVER yields one card.
    draw_req = 1'b1;
    predict_draw(k);
    repeat (k + 2) @(negedge clk);
    draw_req = 1'b0;
    repeat (30) @(negedge clk);
    wait_idle();
    check("held_left", 32'(cards_left), 32'd51);
    check("held_idle", 32'(busy), 32'd0);

    // Asynchronous reset during SEARCH.
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check("search_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    refill_model();
    check("mid_rst_card_valid", 32'(card_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_card_value", 32'(card_value), 32'd0);
    check("mid_rst_card_rank", 32'(card_rank), 32'd0);
    check("mid_rst_card_is_ace", 32'(card_is_ace), 32'd0);
    check("mid_rst_cards_left", 32'(cards_left), 32'd52);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    draw(k);
    wait_idle();
    check("left_after_reset_draw", 32'(cards_left), 32'd51);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
